// File: rtl/branch_resolve_bht_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_bht_pkg
//  Purpose  : Branch op encodings and BHT counter constants/helpers.
//  Revision : 1.0
// ============================================================================
package branch_resolve_bht_pkg;

    localparam int BHT_CNT_W = 2;
    localparam logic [BHT_CNT_W-1:0] BHT_CNT_INIT = 2'b01;

    // Conditional branches reuse RV32 funct3; the unused 3'b010 slot marks JAL/JALR.
    localparam logic [2:0] BR_BEQ      = 3'b000;
    localparam logic [2:0] BR_BNE      = 3'b001;
    localparam logic [2:0] BR_JAL_JALR = 3'b010;
    localparam logic [2:0] BR_BLT      = 3'b100;
    localparam logic [2:0] BR_BGE      = 3'b101;
    localparam logic [2:0] BR_BLTU     = 3'b110;
    localparam logic [2:0] BR_BGEU     = 3'b111;

    function automatic logic [BHT_CNT_W-1:0] sat_update(
        input logic [BHT_CNT_W-1:0] cnt,
        input logic                 taken
    );
        logic [BHT_CNT_W-1:0] res;
        res = cnt;
        if (taken && (cnt != {BHT_CNT_W{1'b1}})) begin
            res = cnt + BHT_CNT_W'(1);
        end else if (!taken && (cnt != '0)) begin
            res = cnt - BHT_CNT_W'(1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_bht_counters.sv
`default_nettype none
// ============================================================================
//  Module   : bht_counter_array
//  Purpose  : Array of 2-bit saturating counters, async read, single write.
//  Revision : 1.0
// ============================================================================
module bht_counter_array
    import branch_resolve_bht_pkg::*;
#(
    parameter int                   DEPTH = 64,
    parameter int                   IDX_W = 6,
    parameter logic [BHT_CNT_W-1:0] INIT  = BHT_CNT_INIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [BHT_CNT_W-1:0] rd_cnt_o,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic                 wr_taken_i
);

    logic [BHT_CNT_W-1:0] cnt_q [DEPTH];
    logic [BHT_CNT_W-1:0] w_wr_next;

    assign w_wr_next = sat_update(cnt_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= INIT;
            end
        end else if (wr_en_i) begin
            cnt_q[wr_idx_i] <= w_wr_next;
        end
    end

    // Read is the pre-update value; a same-cycle write is not bypassed.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module   : branch_resolve_bht
//  Purpose  : EX-stage branch resolution, BHT prediction/training, redirect.
//  Revision : 1.0
// ============================================================================
module branch_resolve_bht
    import branch_resolve_bht_pkg::*;
#(
    parameter int                   XLEN      = 32,
    parameter int                   BHT_DEPTH = 64,
    parameter int                   IDX_LSB   = 2,
    parameter logic [BHT_CNT_W-1:0] CNT_INIT  = BHT_CNT_INIT,
    parameter int                   STAT_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [2:0]        ex_op,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic [XLEN-1:0]   ex_pc_plus4,
    input  logic [XLEN-1:0]   data1,
    input  logic [XLEN-1:0]   data2,
    output logic              ex_taken,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [IDX_W-1:0]     w_if_idx;
    logic [IDX_W-1:0]     w_ex_idx;
    logic [BHT_CNT_W-1:0] w_if_cnt;
    logic                 w_taken;
    logic                 w_res;
    logic                 w_mispred;

    logic                 redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]      redirect_pc_q,    redirect_pc_d;
    logic [STAT_W-1:0]    branch_count_q,   branch_count_d;
    logic [STAT_W-1:0]    mispred_count_q,  mispred_count_d;

    assign w_if_idx = if_pc[IDX_LSB +: IDX_W];
    assign w_ex_idx = ex_pc[IDX_LSB +: IDX_W];

    always_comb begin
        w_taken = 1'b0;
        case (ex_op)
            BR_BEQ:      w_taken = (data1 == data2);
            BR_BNE:      w_taken = (data1 != data2);
            BR_BLT:      w_taken = ($signed(data1) <  $signed(data2));
            BR_BGE:      w_taken = ($signed(data1) >= $signed(data2));
            BR_BLTU:     w_taken = (data1 <  data2);
            BR_BGEU:     w_taken = (data1 >= data2);
            BR_JAL_JALR: w_taken = 1'b1;
            default:     w_taken = 1'b0;
        endcase
    end

    // While a redirect is in flight the EX slot holds a wrong-path instruction.
    assign w_res     = ex_valid & ex_is_branch & ~stall & ~redirect_valid_q;
    assign w_mispred = w_res & (w_taken != ex_pred_taken);

    bht_counter_array #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W),
        .INIT  (CNT_INIT)
    ) u_bht (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_idx_i   (w_if_idx),
        .rd_cnt_o   (w_if_cnt),
        .wr_en_i    (w_res),
        .wr_idx_i   (w_ex_idx),
        .wr_taken_i (w_taken)
    );

    always_comb begin
        redirect_valid_d = w_mispred;
        redirect_pc_d    = redirect_pc_q;
        branch_count_d   = branch_count_q;
        mispred_count_d  = mispred_count_q;
        if (w_mispred) begin
            redirect_pc_d = w_taken ? ex_target : ex_pc_plus4;
        end
        if (w_res && (branch_count_q != STAT_MAX)) begin
            branch_count_d = branch_count_q + STAT_W'(1);
        end
        if (w_mispred && (mispred_count_q != STAT_MAX)) begin
            mispred_count_d = mispred_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            branch_count_q   <= '0;
            mispred_count_q  <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_count_q   <= branch_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign if_pred_taken  = w_if_cnt[BHT_CNT_W-1];
    assign ex_taken       = w_taken;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign branch_count   = branch_count_q;
    assign mispred_count  = mispred_count_q;

    // PC bits outside the index field are intentionally ignored by the lookup.
    logic w_unused_pc;
    assign w_unused_pc = ^{if_pc, ex_pc};

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_bht.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_resolve_bht
//  Purpose  : Directed self-checking bench for branch_resolve_bht.
//  Revision : 1.0
// ============================================================================
module tb_branch_resolve_bht;
    import branch_resolve_bht_pkg::*;

    localparam int XLEN   = 32;
    localparam int STAT_W = 4;

    logic              clk;
    logic              reset_n;
    logic [XLEN-1:0]   if_pc;
    logic              if_pred_taken;
    logic              stall;
    logic              ex_valid;
    logic              ex_is_branch;
    logic [2:0]        ex_op;
    logic [XLEN-1:0]   ex_pc;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_target;
    logic [XLEN-1:0]   ex_pc_plus4;
    logic [XLEN-1:0]   data1;
    logic [XLEN-1:0]   data2;
    logic              ex_taken;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [STAT_W-1:0] branch_count;
    logic [STAT_W-1:0] mispred_count;

    int total;
    int bad;

    branch_resolve_bht #(
        .XLEN      (XLEN),
        .BHT_DEPTH (64),
        .IDX_LSB   (2),
        .CNT_INIT  (2'b01),
        .STAT_W    (STAT_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .stall          (stall),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_op          (ex_op),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_target      (ex_target),
        .ex_pc_plus4    (ex_pc_plus4),
        .data1          (data1),
        .data2          (data2),
        .ex_taken       (ex_taken),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        exp;
    } cond_vec_t;

    cond_vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_br();
        ex_valid      = 1'b0;
        ex_is_branch  = 1'b0;
        ex_pred_taken = 1'b0;
    endtask

    task automatic set_br(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] d1,
                          input logic [31:0] d2, input logic pred, input logic [31:0] tgt);
        ex_valid      = 1'b1;
        ex_is_branch  = 1'b1;
        ex_op         = op;
        ex_pc         = pc;
        data1         = d1;
        data2         = d2;
        ex_pred_taken = pred;
        ex_target     = tgt;
        ex_pc_plus4   = pc + 32'd4;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clr_br();
        stall   = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset_n = 1'b0;
        if_pc = '0; stall = 1'b0; ex_op = '0; ex_pc = '0;
        ex_target = '0; ex_pc_plus4 = '0; data1 = '0; data2 = '0;
        clr_br();

        vecs[0]  = '{BR_BEQ,      32'd5,        32'd5,        1'b1};
        vecs[1]  = '{BR_BEQ,      32'd5,        32'd6,        1'b0};
        vecs[2]  = '{BR_BNE,      32'd5,        32'd6,        1'b1};
        vecs[3]  = '{BR_BNE,      32'd7,        32'd7,        1'b0};
        vecs[4]  = '{BR_BLT,      32'hFFFFFFFF, 32'd1,        1'b1};
        vecs[5]  = '{BR_BLT,      32'd1,        32'hFFFFFFFF, 1'b0};
        vecs[6]  = '{BR_BLT,      32'h80000000, 32'h7FFFFFFF, 1'b1};
        vecs[7]  = '{BR_BGE,      32'h7FFFFFFF, 32'h80000000, 1'b1};
        vecs[8]  = '{BR_BGE,      32'd3,        32'd3,        1'b1};
        vecs[9]  = '{BR_BLTU,     32'hFFFFFFFF, 32'd1,        1'b0};
        vecs[10] = '{BR_BLTU,     32'd1,        32'hFFFFFFFF, 1'b1};
        vecs[11] = '{BR_BGEU,     32'h80000000, 32'h7FFFFFFF, 1'b1};
        vecs[12] = '{BR_BGEU,     32'd0,        32'd1,        1'b0};
        vecs[13] = '{BR_JAL_JALR, 32'd0,        32'd1,        1'b1};
        vecs[14] = '{3'b011,      32'd5,        32'd5,        1'b0};

        // 1. reset state
        do_reset();
        if_pc = 32'h100;
        #1;
        chk("rst_pred",    {31'd0, if_pred_taken},  32'd0);
        chk("rst_rv",      {31'd0, redirect_valid}, 32'd0);
        chk("rst_rpc",     redirect_pc,             32'd0);
        chk("rst_bcnt",    {28'd0, branch_count},   32'd0);
        chk("rst_mcnt",    {28'd0, mispred_count},  32'd0);

        // condition table, not resolved (ex_valid = 0)
        for (int i = 0; i < 15; i++) begin
            ex_op = vecs[i].op; data1 = vecs[i].d1; data2 = vecs[i].d2;
            #1;
            chk($sformatf("cond[%0d]", i), {31'd0, ex_taken}, {31'd0, vecs[i].exp});
        end
        tick();
        chk("cond_no_res", {28'd0, branch_count}, 32'd0);

        // 2. BLT signed taken -> redirect; BLTU same operands not taken
        set_br(BR_BLT, 32'h200, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h300);
        #1;
        chk("blt_taken", {31'd0, ex_taken}, 32'd1);
        tick();
        chk("blt_rv",  {31'd0, redirect_valid}, 32'd1);
        chk("blt_rpc", redirect_pc, 32'h300);
        clr_br();
        tick();
        chk("blt_rv_drop", {31'd0, redirect_valid}, 32'd0);
        chk("blt_rpc_hold", redirect_pc, 32'h300);
        chk("blt_bcnt", {28'd0, branch_count}, 32'd1);
        set_br(BR_BLTU, 32'h200, 32'hFFFFFFFF, 32'd1, 1'b0, 32'h300);
        #1;
        chk("bltu_taken", {31'd0, ex_taken}, 32'd0);
        tick();
        clr_br();
        chk("bltu_rv",   {31'd0, redirect_valid}, 32'd0);
        chk("bltu_bcnt", {28'd0, branch_count},   32'd2);
        chk("bltu_mcnt", {28'd0, mispred_count},  32'd1);

        // 3. train one PC taken three times
        do_reset();
        if_pc = 32'h400;
        set_br(BR_BEQ, 32'h400, 32'd9, 32'd9, 1'b0, 32'h480);
        #1;
        chk("tr_nobypass", {31'd0, if_pred_taken}, 32'd0);
        tick();
        chk("tr_pred1", {31'd0, if_pred_taken}, 32'd1);
        chk("tr_rv",    {31'd0, redirect_valid}, 32'd1);
        clr_br();
        tick();
        set_br(BR_BEQ, 32'h400, 32'd9, 32'd9, if_pred_taken, 32'h480);
        tick();
        chk("tr_rv2", {31'd0, redirect_valid}, 32'd0);
        set_br(BR_BEQ, 32'h400, 32'd9, 32'd9, if_pred_taken, 32'h480);
        tick();
        clr_br();
        chk("tr_pred3", {31'd0, if_pred_taken}, 32'd1);
        chk("tr_bcnt",  {28'd0, branch_count},  32'd3);
        chk("tr_mcnt",  {28'd0, mispred_count}, 32'd1);
        // counter now 11: one not-taken leaves 10, prediction still taken
        set_br(BR_BEQ, 32'h400, 32'd9, 32'd8, 1'b1, 32'h480);
        tick();
        clr_br();
        chk("tr_sat_hi", {31'd0, if_pred_taken}, 32'd1);
        chk("tr_nt_rv",  {31'd0, redirect_valid}, 32'd1);
        chk("tr_nt_rpc", redirect_pc, 32'h404);
        tick();

        // 4. branch in the cycle after a mispredict is ignored
        do_reset();
        set_br(BR_BNE, 32'h500, 32'd1, 32'd2, 1'b0, 32'h600);
        tick();
        chk("wp_rv", {31'd0, redirect_valid}, 32'd1);
        if_pc = 32'h540;
        set_br(BR_BEQ, 32'h540, 32'd3, 32'd3, 1'b0, 32'h700);
        tick();
        clr_br();
        chk("wp_rv2",   {31'd0, redirect_valid}, 32'd0);
        chk("wp_rpc",   redirect_pc, 32'h600);
        chk("wp_bcnt",  {28'd0, branch_count},  32'd1);
        chk("wp_mcnt",  {28'd0, mispred_count}, 32'd1);
        chk("wp_bht",   {31'd0, if_pred_taken}, 32'd0);

        // 5. stalled mispredict held four cycles
        do_reset();
        stall = 1'b1;
        set_br(BR_BGEU, 32'h800, 32'd5, 32'd3, 1'b0, 32'h900);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("st_rv[%0d]", i),   {31'd0, redirect_valid}, 32'd0);
            chk($sformatf("st_bcnt[%0d]", i), {28'd0, branch_count},   32'd0);
        end
        stall = 1'b0;
        tick();
        clr_br();
        chk("st_rel_rv",   {31'd0, redirect_valid}, 32'd1);
        chk("st_rel_rpc",  redirect_pc, 32'h900);
        chk("st_rel_bcnt", {28'd0, branch_count},  32'd1);
        chk("st_rel_mcnt", {28'd0, mispred_count}, 32'd1);
        tick();
        chk("st_once_rv",  {31'd0, redirect_valid}, 32'd0);

        // 6. async reset while redirect pending
        do_reset();
        if_pc = 32'hA00;
        set_br(BR_JAL_JALR, 32'hA00, 32'd0, 32'd0, 1'b0, 32'hB00);
        tick();
        clr_br();
        chk("ar_rv_pre",   {31'd0, redirect_valid}, 32'd1);
        chk("ar_pred_pre", {31'd0, if_pred_taken},  32'd1);
        reset_n = 1'b0;
        #1;
        chk("ar_rv",   {31'd0, redirect_valid}, 32'd0);
        chk("ar_rpc",  redirect_pc, 32'd0);
        chk("ar_bcnt", {28'd0, branch_count},  32'd0);
        chk("ar_mcnt", {28'd0, mispred_count}, 32'd0);
        chk("ar_pred", {31'd0, if_pred_taken}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 7. statistics and counter saturation
        do_reset();
        if_pc = 32'hC00;
        set_br(BR_BNE, 32'hC00, 32'd1, 32'd1, 1'b0, 32'hD00);
        repeat (17) tick();
        clr_br();
        chk("sat_bcnt", {28'd0, branch_count},  32'd15);
        chk("sat_mcnt0", {28'd0, mispred_count}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            set_br(BR_BLTU, 32'hC00, 32'd0, 32'd1, 1'b0, 32'hD00);
            tick();
            clr_br();
            if (i == 0) chk("sat_lo", {31'd0, if_pred_taken}, 32'd0);
            tick();
        end
        chk("sat_mcnt",  {28'd0, mispred_count}, 32'd15);
        chk("sat_bcnt2", {28'd0, branch_count},  32'd15);
        chk("sat_pred",  {31'd0, if_pred_taken}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
